// File: rtl/adc_sim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_sim_pkg
// Purpose  : Shared frame geometry, status layout and state encoding for the
//            emulated serial ADC.
// Revision : 1.0 - initial release
// ============================================================================
package adc_sim_pkg;

  localparam int ADC_FRAME_BITS     = 16;
  localparam int ADC_ADDR_FIRST_BIT = 2;
  localparam int ADC_ADDR_WIDTH     = 3;
  localparam int ADC_DATA_WIDTH     = 12;

  localparam int ADC_STAT_BUSY_BIT  = 3;
  localparam int ADC_STAT_COUNT_LSB = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } adc_state_e;

endpackage : adc_sim_pkg
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_detect
// Purpose  : Multi-flop synchronizer for an asynchronous input followed by
//            single-cycle rise/fall pulse generation.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  =  sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] &  prev_q;

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/adc_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_responder
// Purpose  : Emulates an 8-channel 12-bit serial ADC toward an SPI master,
//            returning channel values written by the simulator MCU.
// Revision : 1.0 - initial release
// ============================================================================
module adc_spi_responder
  import adc_sim_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        sysclk,
  input  logic        sysreset,
  input  logic [15:0] data_in,
  input  logic [2:0]  chan_sel,
  input  logic        chan_load,
  input  logic        adc_cs_n,
  input  logic        adc_sclk,
  input  logic        adc_saddr,
  output logic        adc_sdat,
  output logic [15:0] status_out,
  output logic        frame_done,
  output logic        frame_error
);

  localparam int        PAD_BITS   = ADC_FRAME_BITS - ADC_DATA_WIDTH;
  localparam int        CNT_W      = $clog2(ADC_FRAME_BITS);
  localparam logic [CNT_W-1:0] ADDR_FIRST = CNT_W'(ADC_ADDR_FIRST_BIT);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADC_ADDR_FIRST_BIT + ADC_ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(ADC_FRAME_BITS - 1);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic saddr_lvl, saddr_rise, saddr_fall;

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_i  (sysclk),
    .rst_i  (sysreset),
    .d_i    (adc_cs_n),
    .level_o(cs_lvl),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .clk_i  (sysclk),
    .rst_i  (sysreset),
    .d_i    (adc_sclk),
    .level_o(sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_saddr (
    .clk_i  (sysclk),
    .rst_i  (sysreset),
    .d_i    (adc_saddr),
    .level_o(saddr_lvl),
    .rise_o (saddr_rise),
    .fall_o (saddr_fall)
  );

  logic unused_bits;
  assign unused_bits = ^{data_in[15:ADC_DATA_WIDTH], cs_lvl, sclk_lvl, saddr_rise, saddr_fall};

  // Flop-based channel file so the word load can read it in the same cycle.
  logic [ADC_DATA_WIDTH-1:0] chan_q [NUM_CHANNELS];

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) chan_q[i] <= '0;
    end else if (chan_load) begin
      chan_q[chan_sel] <= data_in[ADC_DATA_WIDTH-1:0];
    end
  end

  adc_state_e                 state_q, state_d;
  logic [CNT_W-1:0]           bitcnt_q, bitcnt_d;
  logic [ADC_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADC_ADDR_WIDTH-1:0]  next_chan_q, next_chan_d;
  logic [ADC_ADDR_WIDTH-1:0]  stat_addr_q, stat_addr_d;
  logic [ADC_FRAME_BITS-1:0]  shift_q, shift_d;
  logic [7:0]                 count_q, count_d;
  logic                       sdat_q, sdat_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      addr_q      <= '0;
      next_chan_q <= '0;
      stat_addr_q <= '0;
      shift_q     <= '0;
      count_q     <= '0;
      sdat_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      addr_q      <= addr_d;
      next_chan_q <= next_chan_d;
      stat_addr_q <= stat_addr_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      sdat_q      <= sdat_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    addr_d      = addr_q;
    next_chan_d = next_chan_q;
    stat_addr_d = stat_addr_q;
    shift_d     = shift_q;
    count_d     = count_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d     = SHIFT;
          bitcnt_d    = '0;
          next_chan_d = '0;
          shift_d     = {{PAD_BITS{1'b0}}, chan_q[next_chan_d]};
        end
      end
      SHIFT: begin
        // CS edges win; any SCLK edge in the same cycle is dropped.
        if (cs_rise || cs_fall) begin
          if (cs_rise) begin
            state_d = IDLE;
            err_d   = (bitcnt_q != '0);
          end
        end else if (sclk_rise) begin
          if (bitcnt_q >= ADDR_FIRST && bitcnt_q <= ADDR_LAST) begin
            addr_d = {addr_q[ADC_ADDR_WIDTH-2:0], saddr_lvl};
          end
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == LAST_BIT) begin
            next_chan_d = addr_d;
            stat_addr_d = addr_d;
            shift_d     = {{PAD_BITS{1'b0}}, chan_q[next_chan_d]};
            done_d      = 1'b1;
            count_d     = count_q + 8'd1;
          end
        end else if (sclk_fall && bitcnt_q != '0) begin
          // No shift before the first rising edge keeps bit 15 presented.
          shift_d = {shift_q[ADC_FRAME_BITS-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase

    sdat_d = (state_d == SHIFT) ? shift_d[ADC_FRAME_BITS-1] : 1'b0;
  end

  always_comb begin
    status_out                                 = '0;
    status_out[ADC_ADDR_WIDTH-1:0]             = stat_addr_q;
    status_out[ADC_STAT_BUSY_BIT]              = (state_q == SHIFT);
    status_out[ADC_STAT_COUNT_LSB +: 8]        = count_q;
  end

  assign adc_sdat    = sdat_q;
  assign frame_done  = done_q;
  assign frame_error = err_q;

endmodule : adc_spi_responder
`default_nettype wire

// File: tb/tb_adc_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_spi_responder
// Purpose  : Self-checking bench driving an SPI master model against the
//            ADC responder, with a channel/frame reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_spi_responder;

  logic        sysclk    = 1'b0;
  logic        sysreset  = 1'b1;
  logic [15:0] data_in   = '0;
  logic [2:0]  chan_sel  = '0;
  logic        chan_load = 1'b0;
  logic        adc_cs_n  = 1'b1;
  logic        adc_sclk  = 1'b1;
  logic        adc_saddr = 1'b0;
  logic        adc_sdat;
  logic [15:0] status_out;
  logic        frame_done;
  logic        frame_error;

  adc_spi_responder #(.NUM_CHANNELS(8), .SYNC_STAGES(2)) dut (
    .sysclk     (sysclk),
    .sysreset   (sysreset),
    .data_in    (data_in),
    .chan_sel   (chan_sel),
    .chan_load  (chan_load),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .adc_saddr  (adc_saddr),
    .adc_sdat   (adc_sdat),
    .status_out (status_out),
    .frame_done (frame_done),
    .frame_error(frame_error)
  );

  always #10 sysclk = ~sysclk;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  // Cycles of high pulse: equals the event count only if each pulse is one cycle.
  always @(negedge sysclk) begin
    if (frame_done === 1'b1)  done_cnt++;
    if (frame_error === 1'b1) err_cnt++;
  end

  logic [11:0] chan_m [8];
  logic [11:0] next_word_m;
  logic [7:0]  m_count;
  int          m_frames;
  int          half;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_chan(input logic [2:0] sel, input logic [11:0] val);
    chan_sel  = sel;
    data_in   = {4'($urandom_range(15)), val};
    chan_load = 1'b1;
    wait_cyc(1);
    chan_load = 1'b0;
    chan_m[sel] = val;
  endtask

  task automatic cs_fall();
    adc_cs_n    = 1'b0;
    next_word_m = chan_m[0];
    wait_cyc(10);
  endtask

  // SCLK idles high; master changes SADDR on falling and samples SDAT on rising.
  task automatic shift_bits(input logic [2:0] addr, input int nbits, input int wr_at,
                            input logic [2:0] wr_sel, input logic [11:0] wr_val,
                            output logic [15:0] rx);
    logic [15:0] mosi;
    mosi       = 16'($urandom);
    mosi[13:11] = addr;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      if (i == wr_at) write_chan(wr_sel, wr_val);
      adc_sclk  = 1'b0;
      adc_saddr = mosi[15];
      mosi      = mosi << 1;
      wait_cyc(half);
      adc_sclk  = 1'b1;
      rx        = {rx[14:0], adc_sdat};
      wait_cyc(half);
    end
  endtask

  task automatic run_frame(input logic [2:0] addr, input int wr_at,
                           input logic [2:0] wr_sel, input logic [11:0] wr_val);
    logic [15:0] rx;
    logic [15:0] exp;
    exp = {4'h0, next_word_m};
    shift_bits(addr, 16, wr_at, wr_sel, wr_val, rx);
    wait_cyc(2);
    m_count     = m_count + 8'd1;
    m_frames++;
    next_word_m = chan_m[addr];
    check("frame_data", {16'h0, rx}, {16'h0, exp});
    check("status_frame", {16'h0, status_out}, {16'h0, m_count, 4'h0, 1'b1, addr});
  endtask

  initial begin
    logic [15:0] dummy;
    logic [2:0]  a;
    half     = 25;
    m_count  = '0;
    m_frames = 0;
    for (int i = 0; i < 8; i++) chan_m[i] = '0;
    next_word_m = '0;

    // Reset state
    wait_cyc(3);
    check("rst_status", {16'h0, status_out}, 32'h0);
    check("rst_sdat", {31'h0, adc_sdat}, 32'h0);
    check("rst_done", {31'h0, frame_done}, 32'h0);
    check("rst_error", {31'h0, frame_error}, 32'h0);
    sysreset = 1'b0;
    wait_cyc(5);

    for (int i = 0; i < 8; i++) write_chan(3'(i), 12'($urandom));
    write_chan(3'd0, 12'hABC);
    write_chan(3'd3, 12'h123);

    // Single frame, then a back-to-back frame with CS held low
    cs_fall();
    check("busy_after_cs", {31'h0, status_out[3]}, 32'h1);
    run_frame(3'd3, -1, 3'd0, 12'h0);
    check("count_1", {24'h0, status_out[15:8]}, 32'h1);
    run_frame(3'd5, -1, 3'd0, 12'h0);
    check("done_pulses_2", done_cnt, 2);

    // Random back-to-back frames with writes between them
    for (int k = 0; k < 6; k++) begin
      write_chan(3'($urandom_range(7)), 12'($urandom));
      run_frame(3'($urandom_range(7)), -1, 3'd0, 12'h0);
    end
    adc_cs_n = 1'b1;
    wait_cyc(10);
    check("idle_sdat", {31'h0, adc_sdat}, 32'h0);
    check("idle_status", {16'h0, status_out}, {16'h0, m_count, 4'h0, 1'b0, status_out[2:0]});
    check("no_error_yet", err_cnt, 0);

    // Aborted frame after 7 SCLKs
    cs_fall();
    shift_bits(3'($urandom_range(7)), 7, -1, 3'd0, 12'h0, dummy);
    adc_cs_n = 1'b1;
    wait_cyc(10);
    check("abort_error_pulse", err_cnt, 1);
    check("abort_count", {24'h0, status_out[15:8]}, {24'h0, m_count});
    check("abort_sdat", {31'h0, adc_sdat}, 32'h0);
    check("abort_done", done_cnt, m_frames);

    // Frame after abort returns channel 0; value write during a frame
    write_chan(3'd0, 12'hFFF);
    cs_fall();
    run_frame(3'd0, 7, 3'd0, 12'h555);
    run_frame(3'd0, -1, 3'd0, 12'h0);

    // Count wrap at 256 frames with a faster SCLK
    half = 6;
    while (m_frames < 256) begin
      if ($urandom_range(1) == 1) write_chan(3'($urandom_range(7)), 12'($urandom));
      run_frame(3'($urandom_range(7)), -1, 3'd0, 12'h0);
    end
    check("wrap_count", {24'h0, status_out[15:8]}, 32'h0);
    check("wrap_done_pulses", done_cnt, 256);

    // Reset mid-frame with CS held low
    cs_fall();
    a = 3'($urandom_range(7));
    shift_bits(a, 8, -1, 3'd0, 12'h0, dummy);
    sysreset = 1'b1;
    wait_cyc(2);
    check("midrst_status", {16'h0, status_out}, 32'h0);
    check("midrst_sdat", {31'h0, adc_sdat}, 32'h0);
    check("midrst_done", {31'h0, frame_done}, 32'h0);
    check("midrst_error", {31'h0, frame_error}, 32'h0);
    for (int i = 0; i < 8; i++) chan_m[i] = '0;
    m_count     = '0;
    next_word_m = chan_m[0];
    sysreset = 1'b0;
    wait_cyc(2);
    check("midrst_not_busy_2", {31'h0, status_out[3]}, 32'h0);
    wait_cyc(1);
    check("midrst_busy_3", {31'h0, status_out[3]}, 32'h1);
    wait_cyc(5);
    run_frame(3'($urandom_range(7)), -1, 3'd0, 12'h0);
    adc_cs_n = 1'b1;
    wait_cyc(10);
    check("final_error_pulses", err_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_adc_spi_responder
`default_nettype wire
